// File: rtl/intt_gs_butterfly_pkg.sv
// rtl/intt_gs_butterfly_pkg.sv - shared constants, state type, twiddle table and bit-reverse for the INTT core
package intt_gs_butterfly_pkg;

    localparam int INTT_P     = 17;
    localparam int INTT_N     = 8;
    localparam int INTT_LOGN  = $clog2(INTT_N);
    localparam int INTT_LOGP  = $clog2(INTT_P);
    localparam int INTT_N_INV = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BFLY  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } intt_state_t;

    // Powers of the inverse root iw = 2 (order 8 mod 17).
    function automatic logic [INTT_LOGP-1:0] iw_table(input logic [INTT_LOGN-1:0] k);
        logic [INTT_LOGP-1:0] r;
        r = 5'd1;
        case (k)
            3'd0: r = 5'd1;
            3'd1: r = 5'd2;
            3'd2: r = 5'd4;
            3'd3: r = 5'd8;
            3'd4: r = 5'd16;
            3'd5: r = 5'd15;
            3'd6: r = 5'd13;
            3'd7: r = 5'd9;
            default: r = 5'd1;
        endcase
        return r;
    endfunction

    function automatic logic [INTT_LOGN-1:0] bitrev(input logic [INTT_LOGN-1:0] x);
        logic [INTT_LOGN-1:0] r;
        for (int b = 0; b < INTT_LOGN; b++) begin
            r[b] = x[INTT_LOGN-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/intt_gs_butterfly_unit.sv
// rtl/intt_gs_butterfly_unit.sv - combinational modular Gentleman-Sande butterfly
module gs_butterfly_unit
    import intt_gs_butterfly_pkg::*;
#(
    parameter int p    = INTT_P,
    parameter int logP = INTT_LOGP
) (
    input  logic [logP-1:0] u,
    input  logic [logP-1:0] v,
    input  logic [logP-1:0] tw,
    output logic [logP-1:0] sum,
    output logic [logP-1:0] prod
);

    localparam logic [logP:0]     P_W  = (logP+1)'(p);
    localparam logic [2*logP-1:0] P_2W = (2*logP)'(p);

    logic [logP:0]     add_full;
    logic [logP:0]     sub_full;
    logic [logP-1:0]   diff;
    logic [2*logP-1:0] product;

    always_comb begin
        add_full = {1'b0, u} + {1'b0, v};
        sum      = (add_full >= P_W) ? logP'(add_full - P_W) : logP'(add_full);
        // Inputs are already reduced, so one correction step suffices.
        sub_full = (u >= v) ? ({1'b0, u} - {1'b0, v})
                            : ({1'b0, u} + P_W - {1'b0, v});
        diff     = logP'(sub_full);
        product  = {{logP{1'b0}}, diff} * {{logP{1'b0}}, tw};
        prod     = logP'(product % P_2W);
    end

endmodule

// File: rtl/intt_gs_butterfly.sv
// rtl/intt_gs_butterfly.sv - sequential inverse NTT, one GS butterfly per cycle, then N^-1 scaling
module intt_gs_butterfly
    import intt_gs_butterfly_pkg::*;
#(
    parameter int p     = INTT_P,
    parameter int N     = INTT_N,
    parameter int logN  = $clog2(N),
    parameter int logP  = $clog2(p),
    parameter int Nb    = N * logP,
    parameter int N_INV = INTT_N_INV
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_in_ready,
    input  logic [Nb-1:0] poly,
    output logic          busy,
    output logic          done,
    output logic [Nb-1:0] poly_out
);

    localparam logic [logP-1:0] P_L        = logP'(p);
    localparam logic [logP-1:0] NINV_L     = logP'(N_INV);
    localparam logic [logN-1:0] ONE        = logN'(1);
    localparam logic [logN-1:0] LAST_PAIR  = logN'(N/2 - 1);
    localparam logic [logN-1:0] LAST_STAGE = logN'(logN - 1);
    localparam logic [logN-1:0] LAST_IDX   = logN'(N - 1);

    intt_state_t state, state_next;

    logic [logP-1:0] a [N];
    logic [logN-1:0] stage;
    logic [logN-1:0] pair;
    logic [logN-1:0] idx;

    logic [logN-1:0] s_amt;
    logic [logN-1:0] lo_mask;
    logic [logN-1:0] j_lo;
    logic [logN-1:0] j_hi;
    logic [logN-1:0] tw_idx;
    logic            last_pair;
    logic            last_stage;
    logic            last_idx;

    logic [logP-1:0] bu_u;
    logic [logP-1:0] bu_v;
    logic [logP-1:0] bu_tw;
    logic [logP-1:0] bu_sum;
    logic [logP-1:0] bu_prod;

    // len = 2^s_amt; pair k maps to j = (k/len)*2*len + k%len, twiddle index (k%len) << stage.
    assign s_amt   = LAST_STAGE - stage;
    assign lo_mask = (ONE << s_amt) - ONE;
    assign j_lo    = ((pair & ~lo_mask) << 1) | (pair & lo_mask);
    assign j_hi    = j_lo | (ONE << s_amt);
    assign tw_idx  = (pair & lo_mask) << stage;

    assign last_pair  = (pair == LAST_PAIR);
    assign last_stage = (stage == LAST_STAGE);
    assign last_idx   = (idx == LAST_IDX);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = data_in_ready ? ST_BFLY : ST_IDLE;
            ST_BFLY:  state_next = (last_pair && last_stage) ? ST_SCALE : ST_BFLY;
            ST_SCALE: state_next = last_idx ? ST_DONE : ST_SCALE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The scaling pass reuses the butterfly multiplier with v = 0.
    always_comb begin
        bu_u  = a[j_lo];
        bu_v  = a[j_hi];
        bu_tw = iw_table(tw_idx);
        if (state == ST_SCALE) begin
            bu_u  = a[bitrev(idx)];
            bu_v  = '0;
            bu_tw = NINV_L;
        end
    end

    gs_butterfly_unit #(
        .p    (p),
        .logP (logP)
    ) u_bfly (
        .u    (bu_u),
        .v    (bu_v),
        .tw   (bu_tw),
        .sum  (bu_sum),
        .prod (bu_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stage    <= '0;
            pair     <= '0;
            idx      <= '0;
            poly_out <= '0;
            for (int i = 0; i < N; i++) begin
                a[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            a[i] <= poly[i*logP +: logP] % P_L;
                        end
                        stage <= '0;
                        pair  <= '0;
                        idx   <= '0;
                    end
                end
                ST_BFLY: begin
                    a[j_lo] <= bu_sum;
                    a[j_hi] <= bu_prod;
                    if (last_pair) begin
                        pair  <= '0;
                        stage <= last_stage ? '0 : stage + ONE;
                    end else begin
                        pair <= pair + ONE;
                    end
                end
                ST_SCALE: begin
                    poly_out[idx*logP +: logP] <= bu_prod;
                    idx <= last_idx ? '0 : idx + ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// tb/tb_intt_gs_butterfly.sv - self-checking bench for intt_gs_butterfly
module tb_intt_gs_butterfly;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_in_ready;
    logic [39:0] poly;
    logic        busy;
    logic        done;
    logic [39:0] poly_out;

    int tests = 0;
    int fails = 0;

    intt_gs_butterfly dut (
        .clk           (clk),
        .reset         (reset),
        .data_in_ready (data_in_ready),
        .poly          (poly),
        .busy          (busy),
        .done          (done),
        .poly_out      (poly_out)
    );

    always #5 clk = ~clk;

    // Direct definition: out[n] = 15 * sum_k X[k] * 2^(n*k) mod 17.
    function automatic logic [39:0] ref_intt(input logic [39:0] x);
        logic [39:0] r;
        int acc;
        int w;
        int xk;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                w = 1;
                for (int e = 0; e < n*k; e++) w = (w * 2) % 17;
                xk = int'((x >> (5*k)) & 40'h1f) % 17;
                acc = (acc + xk * w) % 17;
            end
            r[5*n +: 5] = 5'((15 * acc) % 17);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [39:0] x);
        @(negedge clk);
        poly = x;
        data_in_ready = 1'b1;
        @(negedge clk);
        data_in_ready = 1'b0;
        poly = '0;
    endtask

    // Entered one cycle after the acceptance edge.
    task automatic wait_done(input string tag, input logic [39:0] exp);
        int cyc;
        cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 21);
        check({tag, "_done"}, done, 1);
        check({tag, "_out"}, poly_out, exp);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [39:0] x1;
        logic [39:0] x2;
        int cyc;
        int dones;
        logic any_done;

        reset = 1'b1;
        data_in_ready = 1'b0;
        poly = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", poly_out, 0);

        start_run(40'd8);
        check("impulse_busy", busy, 1);
        wait_done("impulse", {8{5'd1}});

        start_run({8{5'd1}});
        wait_done("ones", 40'd1);

        start_run(40'd32);
        wait_done("x1", {5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd9, 5'd13, 5'd15});

        start_run(40'd25);
        wait_done("overrange", {8{5'd1}});

        for (int t = 0; t < 6; t++) begin
            x1 = {8'($urandom), 32'($urandom)};
            start_run(x1);
            wait_done($sformatf("rand%0d", t), ref_intt(x1));
        end

        // Request held high with changing poly throughout a run.
        x1 = {8'($urandom), 32'($urandom)};
        x2 = {8'($urandom), 32'($urandom)};
        @(negedge clk);
        poly = x1;
        data_in_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        dones = 0;
        while (cyc < 21) begin
            poly = {8'($urandom), 32'($urandom)};
            @(negedge clk);
            cyc++;
            if (done) dones++;
        end
        check("hold_done_at21", done, 1);
        check("hold_done_count", dones, 1);
        check("hold_out", poly_out, ref_intt(x1));
        poly = x2;
        @(negedge clk);
        check("hold_idle_gap", busy, 0);
        @(negedge clk);
        check("hold_reaccept", busy, 1);
        data_in_ready = 1'b0;
        poly = '0;
        wait_done("hold_second", ref_intt(x2));

        // Reset in the middle of the butterfly phase.
        start_run({8'($urandom), 32'($urandom)});
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_out", poly_out, 0);
        any_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("midreset_no_stale_done", any_done, 0);
        start_run(40'd8);
        wait_done("after_reset", {8{5'd1}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
